// File: rtl/ftoi_seq.sv
// Sequential IEEE-754 single to int32 converter: one shift per cycle, then round and negate.
// Optional FTOI_TRUNC_EN selects truncation toward zero instead of round-to-nearest-even.
module ftoi_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t      state;
  logic [31:0] mag;
  logic [4:0]  cnt;
  logic        sgn;
  logic        left;
  logic        guard;
  logic        sticky;

  logic        sa;
  logic [7:0]  ea;
  logic [22:0] fa;
  logic        rnd_up;
  logic [31:0] mag_rnd;

  assign sa = a[31];
  assign ea = a[30:23];
  assign fa = a[22:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef FTOI_TRUNC_EN
  assign rnd_up = 1'b0;
`else
  // Left path always has guard=0, so this only ever fires on the right path.
  assign rnd_up = guard & (sticky | mag[0]);
`endif

  assign mag_rnd = mag + {31'b0, rnd_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      res    <= 32'h0;
      ovf    <= 1'b0;
      cnt    <= 5'd0;
      mag    <= 32'h0;
      sgn    <= 1'b0;
      left   <= 1'b0;
      guard  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sgn    <= sa;
            mag    <= {8'b0, 1'b1, fa};
            guard  <= 1'b0;
            sticky <= 1'b0;
            if (ea < 8'd125) begin
              res   <= 32'h0;
              ovf   <= 1'b0;
              state <= DONE;
            end else if (ea == 8'd158 && fa == 23'd0 && sa) begin
              // -2^31 is exactly representable
              res   <= 32'h8000_0000;
              ovf   <= 1'b0;
              state <= DONE;
            end else if (ea >= 8'd158) begin
              res   <= sa ? 32'h8000_0000 : 32'h7FFF_FFFF;
              ovf   <= 1'b1;
              state <= DONE;
            end else if (ea >= 8'd150) begin
              left  <= 1'b1;
              cnt   <= 5'(ea - 8'd150);
              state <= SHIFT;
            end else begin
              left  <= 1'b0;
              cnt   <= 5'(8'd150 - ea);
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (cnt != 5'd0) begin
            if (left) begin
              mag <= mag << 1;
            end else begin
              sticky <= sticky | guard;
              guard  <= mag[0];
              mag    <= mag >> 1;
            end
            cnt <= cnt - 5'd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          res   <= sgn ? -mag_rnd : mag_rnd;
          ovf   <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ftoi_seq.sv
// Directed table-driven bench for ftoi_seq plus backpressure and reset sequences.
module tb_ftoi_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        ovf;

  int tests;
  int failed;

  ftoi_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operand in an IDLE cycle, accept on the next edge, then count cycles to out_valid.
  task automatic convert(input logic [31:0] op, output int lat);
    a = op;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit seen;
    tests = 0;
    failed = 0;

    vecs[0]  = '{32'h3FC0_0000, `ifdef FTOI_TRUNC_EN 32'h1 `else 32'h2 `endif, 1'b0, 26};
    vecs[1]  = '{32'h4020_0000, 32'h0000_0002, 1'b0, 25};
    vecs[2]  = '{32'hC030_0000, `ifdef FTOI_TRUNC_EN 32'hFFFF_FFFE `else 32'hFFFF_FFFD `endif, 1'b0, 25};
    vecs[3]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 27};
    vecs[4]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1};
    vecs[5]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1};
    vecs[6]  = '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1};
    vecs[7]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 10};
    vecs[8]  = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1};
    vecs[9]  = '{32'h3E80_0000, 32'h0000_0000, 1'b0, 28};
    vecs[10] = '{32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0, 3};
    vecs[11] = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1};
    vecs[12] = '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1};
    vecs[13] = '{32'h3FE0_0000, `ifdef FTOI_TRUNC_EN 32'h1 `else 32'h2 `endif, 1'b0, 26};
    vecs[14] = '{32'hCB80_0000, 32'hFF00_0000, 1'b0, 4};
    vecs[15] = '{32'h3FA0_0000, 32'h0000_0001, 1'b0, 26};
    vecs[16] = '{32'h4060_0000, `ifdef FTOI_TRUNC_EN 32'h3 `else 32'h4 `endif, 1'b0, 25};
    vecs[17] = '{32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 26};
    vecs[18] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset in_ready", {31'b0, in_ready}, 32'h1);
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset res", res, 32'h0);
    chk("reset ovf", {31'b0, ovf}, 32'h0);

    foreach (vecs[i]) begin
      convert(vecs[i].a, lat);
      chk($sformatf("vec%0d res", i), res, vecs[i].res);
      chk($sformatf("vec%0d ovf", i), {31'b0, ovf}, {31'b0, vecs[i].ovf});
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      tick();
      chk($sformatf("vec%0d drain", i), {30'b0, out_valid, in_ready}, 32'h1);
    end

    // Backpressure: hold result for 5 cycles while a new operand waits.
    out_ready = 1'b0;
    convert(32'h4040_0000, lat);
    chk("bp first latency", lat, 25);
    a = 32'h4120_0000;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp hold out_valid", {31'b0, out_valid}, 32'h1);
      chk("bp hold res", res, 32'h3);
      chk("bp hold ovf", {31'b0, ovf}, 32'h0);
      chk("bp hold in_ready", {31'b0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp release out_valid", {31'b0, out_valid}, 32'h0);
    chk("bp release in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    chk("bp second accepted", {31'b0, in_ready}, 32'h0);
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    chk("bp second latency", lat, 23);
    chk("bp second res", res, 32'd10);
    tick();

    // Reset during SHIFT drops the conversion.
    a = 32'h3F80_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst in_ready", {31'b0, in_ready}, 32'h1);
    chk("midrst res", res, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst no stale output", {31'b0, seen}, 32'h0);

    // Reset and in_valid together: nothing is accepted.
    rst = 1'b1;
    in_valid = 1'b1;
    a = 32'h4F00_0000;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst+valid in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    chk("rst+valid no output", {31'b0, out_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
